uart_tx: RTL and testbench

UART transmitter: accepts one parallel byte per valid/ready handshake and shifts it out on `tx_pin` as an asynchronous serial frame. The frame is start bit, 8 data bits LSB first, optional parity and 1–2 stop bits. It is the transmit-side counterpart of the UART receive path, sharing its clock and baud parameterisation so both ends of a link are configured identically. It sits between the core's UART register/bus logic and the board-level TX pad.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_cnt.sv | 24 ++
 rtl/uart_tx.sv | 112 +++++++++++
 tb/tb_uart_tx.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, parity modes and the baud-period helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic int uart_cycle(input int clk_mhz, input int baud);
        return (clk_mhz * 1_000_000) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: ticks when the count reaches the terminal value, then wraps to zero.
module uart_baud_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic [15:0] term,
    output logic        tick
);

    logic [15:0] cycle_cnt;

    assign tick = (cycle_cnt == term);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
        end else if (clear || tick) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte input, start + 8 data (LSB first) + optional parity + 1-2 stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FRE   = 27,
    parameter int BAUD_RATE = 9600,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    output logic       tx_data_ready,
    output logic       tx_busy,
    output logic       tx_pin
);

    localparam int          CYCLE    = uart_cycle(CLK_FRE, BAUD_RATE);
    localparam logic [15:0] TERM     = 16'(CYCLE - 1);
    localparam bit          PAR_EN   = (PARITY == PAR_ODD) || (PARITY == PAR_EVEN);
    localparam bit          TWO_STOP = (STOP_BITS == 2);

    generate
        if (CYCLE < 2 || CYCLE > 65535) begin : g_bad_cycle
            $error("uart_tx: CYCLE=%0d outside 2..65535", CYCLE);
        end
    endgenerate

    uart_state_t state, state_next;
    logic [2:0]  bit_cnt, bit_cnt_next;
    logic        stop_cnt, stop_cnt_next;
    logic [7:0]  data_reg;
    logic        par_bit;
    logic        pin_next;
    logic        bit_tick;
    logic        cnt_clear;
    logic        accept;

    assign tx_data_ready = (state == ST_IDLE);
    assign tx_busy       = (state != ST_IDLE);
    assign accept        = tx_data_valid && tx_data_ready;
    // Counter is held at zero in IDLE so the start bit gets a full period.
    assign cnt_clear     = (state_next != state) || (state == ST_IDLE);

    uart_baud_cnt u_baud_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .term  (TERM),
        .tick  (bit_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            tx_pin   <= 1'b1;
        end else begin
            state    <= state_next;
            bit_cnt  <= bit_cnt_next;
            stop_cnt <= stop_cnt_next;
            tx_pin   <= pin_next;
        end
    end

    always_comb begin
        state_next    = state;
        bit_cnt_next  = bit_cnt;
        stop_cnt_next = 1'b0;
        pin_next      = 1'b1;
        case (state)
            ST_IDLE: begin
                if (tx_data_valid) state_next = ST_START;
            end
            ST_START: begin
                pin_next = 1'b0;
                if (bit_tick) state_next = ST_DATA;
            end
            ST_DATA: begin
                pin_next = data_reg[bit_cnt];
                if (bit_tick) begin
                    bit_cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_next = PAR_EN ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                pin_next = par_bit;
                if (bit_tick) state_next = ST_STOP;
            end
            ST_STOP: begin
                stop_cnt_next = stop_cnt;
                if (bit_tick) begin
                    if (stop_cnt == TWO_STOP) state_next = ST_IDLE;
                    else                      stop_cnt_next = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (state_next != ST_DATA) bit_cnt_next = '0;
    end

    // Byte and parity are captured once per frame and held until the next accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_reg <= tx_data;
            par_bit  <= (PARITY == PAR_ODD) ? ~^tx_data : ^tx_data;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CYCLE = 10: framing, parity, stop bits, back-to-back and reset.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic [2:0] valid;
    logic       pin0, pin1, pin2;
    logic       rdy0, rdy1, rdy2;
    logic       busy0, busy1, busy2;
    logic [2:0] pins, rdys, busys;
    int         n_checks = 0;
    int         n_fail   = 0;

    assign pins  = {pin2, pin1, pin0};
    assign rdys  = {rdy2, rdy1, rdy0};
    assign busys = {busy2, busy1, busy0};

    always #5 clk = ~clk;

    uart_tx #(.CLK_FRE(1), .BAUD_RATE(100000), .PARITY(0), .STOP_BITS(1)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_data_valid(valid[0]),
        .tx_data_ready(rdy0), .tx_busy(busy0), .tx_pin(pin0));

    uart_tx #(.CLK_FRE(1), .BAUD_RATE(100000), .PARITY(2), .STOP_BITS(2)) dut_even (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_data_valid(valid[1]),
        .tx_data_ready(rdy1), .tx_busy(busy1), .tx_pin(pin1));

    uart_tx #(.CLK_FRE(1), .BAUD_RATE(100000), .PARITY(1), .STOP_BITS(1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_data_valid(valid[2]),
        .tx_data_ready(rdy2), .tx_busy(busy2), .tx_pin(pin2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Starts on a cycle boundary (+1), returns one clock after ready comes back.
    task automatic send(input int sel, input logic [7:0] b, input bit has_par, input bit par,
                        input int nstop, input bit hold, input bit disturb);
        int n;
        n = 0;
        while (!rdys[sel] && n < 300) begin
            tick(1);
            n++;
        end
        chk("rdy_wait", rdys[sel], 1);
        tx_data    = b;
        valid[sel] = 1'b1;
        tick(1);
        if (!hold) valid[sel] = 1'b0;
        chk("accept_pin", pins[sel], 1);
        chk("accept_rdy", rdys[sel], 0);
        chk("accept_busy", busys[sel], 1);
        tick(1);
        chk("start_edge", pins[sel], 0);
        tick(5);
        chk("start_ctr", pins[sel], 0);
        for (int i = 0; i < 8; i++) begin
            if (disturb && i == 3) begin
                tx_data    = ~b;
                valid[sel] = 1'b1;
                tick(1);
                valid[sel] = 1'b0;
                tick(9);
            end else begin
                tick(10);
            end
            chk($sformatf("data%0d_%0h", i, b), pins[sel], b[i]);
        end
        if (has_par) begin
            tick(10);
            chk("parity", pins[sel], par);
        end
        for (int s = 0; s < nstop; s++) begin
            tick(10);
            chk($sformatf("stop%0d", s), pins[sel], 1);
        end
        tick(3);
        chk("rdy_late", rdys[sel], 0);
        tick(1);
        chk("rdy_back", rdys[sel], 1);
        chk("busy_back", busys[sel], 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit low_seen;
        rst_n   = 1'b0;
        valid   = '0;
        tx_data = '0;
        #12;
        chk("rst_pin", pins, 3'b111);
        chk("rst_rdy", rdys, 3'b111);
        chk("rst_busy", busys, 3'b000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        low_seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (pins != 3'b111) low_seen = 1'b1;
        end
        chk("idle_200", low_seen, 0);

        send(0, 8'hA5, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        send(1, 8'h07, 1'b1, 1'b1, 2, 1'b0, 1'b0);
        send(2, 8'h07, 1'b1, 1'b0, 1, 1'b0, 1'b0);

        send(0, 8'h55, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        send(0, 8'hFF, 1'b0, 1'b0, 1, 1'b0, 1'b0);

        send(0, 8'h96, 1'b0, 1'b0, 1, 1'b0, 1'b1);
        tick(5);
        chk("no_late_accept_busy", busy0, 0);
        chk("no_late_accept_pin", pin0, 1);

        tx_data  = 8'hC3;
        valid[0] = 1'b1;
        tick(1);
        valid[0] = 1'b0;
        tick(55);
        chk("pre_rst_bit4", pin0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_pin", pin0, 1);
        chk("async_rst_rdy", rdy0, 1);
        chk("async_rst_busy", busy0, 0);
        #3 rst_n = 1'b1;
        tick(1);
        send(0, 8'h3C, 1'b0, 1'b0, 1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
